pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage RV32I core. It detects load-use hazards and control redirects, and generates the stall/flush enables for the IF/ID, ID/EX and EX/MEM registers. It also generates the EX-stage forwarding selects. A small FSM freezes the whole pipeline while the data memory holds off a request, and latches a sticky error if the memory never answers.

---
 rtl/pipe_ctrl_pkg.sv | 7 +
 rtl/fwd_unit.sv | 17 +
 rtl/pipe_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and forwarding-select codes for the pipeline controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: EX-operand bypass select; MEM results win over WB, loads in MEM are not yet available.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       rd_wren_m_i,
    input  logic       mem_read_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       rd_wren_w_i,
    output logic [1:0] sel_o
);
    always_comb
        sel_o = (rd_wren_m_i && !mem_read_m_i && rd_m_i != 5'd0 && rd_m_i == rs_e_i) ? FWD_MEM :
                (rd_wren_w_i && rd_w_i != 5'd0 && rd_w_i == rs_e_i)                 ? FWD_WB  :
                                                                                      FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for the 5-stage core with memory-hold FSM.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rs1_d,
    input  logic [4:0]       i_rs2_d,
    input  logic [4:0]       i_rs1_e,
    input  logic [4:0]       i_rs2_e,
    input  logic [4:0]       i_rd_e,
    input  logic             i_mem_read_e,
    input  logic             i_redirect_e,
    input  logic [4:0]       i_rd_m,
    input  logic             i_rd_wren_m,
    input  logic             i_mem_read_m,
    input  logic             i_dmem_req_m,
    input  logic             i_dmem_ack,
    input  logic [4:0]       i_rd_w,
    input  logic             i_rd_wren_w,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_stall_ex,
    output logic             o_stall_mem,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    localparam int                WCNT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);
    localparam bit                TO_EN    = (WAIT_MAX != 0);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [1:0]        fwd_a, fwd_b;
    logic              lu, hold, redir, lu_stall;

    fwd_unit u_fwd_a (
        .rs_e_i(i_rs1_e), .rd_m_i(i_rd_m), .rd_wren_m_i(i_rd_wren_m), .mem_read_m_i(i_mem_read_m),
        .rd_w_i(i_rd_w), .rd_wren_w_i(i_rd_wren_w), .sel_o(fwd_a)
    );
    fwd_unit u_fwd_b (
        .rs_e_i(i_rs2_e), .rd_m_i(i_rd_m), .rd_wren_m_i(i_rd_wren_m), .mem_read_m_i(i_mem_read_m),
        .rd_w_i(i_rd_w), .rd_wren_w_i(i_rd_wren_w), .sel_o(fwd_b)
    );

    // On the ack cycle of MEM_WAIT hold drops and the normal RUN priority applies.
    always_comb begin
        lu       = i_mem_read_e && i_rd_e != 5'd0 && (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d);
        hold     = (state_q == ERR) || (state_q == MEM_WAIT ? !i_dmem_ack : (i_dmem_req_m && !i_dmem_ack));
        redir    = !hold && i_redirect_e;
        lu_stall = !hold && !i_redirect_e && lu;
        state_d  = (state_q == ERR) ? ERR :
                   !hold ? RUN :
                   (state_q == MEM_WAIT && TO_EN && wcnt_q == WAIT_LIM) ? ERR : MEM_WAIT;
        wcnt_d   = (state_q == MEM_WAIT && hold) ? wcnt_q + WCNT_W'(1) : '0;
        o_stall_if    = i_reset && (hold || lu_stall);
        o_stall_id    = i_reset && (hold || lu_stall);
        o_stall_ex    = i_reset && hold;
        o_stall_mem   = i_reset && hold;
        o_flush_id    = i_reset && redir;
        o_flush_ex    = i_reset && (redir || lu_stall);
        o_fwd_a       = i_reset ? fwd_a : FWD_RF;
        o_fwd_b       = i_reset ? fwd_b : FWD_RF;
        o_mem_timeout = i_reset && state_q == ERR;
    end

    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (o_stall_if && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (o_flush_id && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table for RUN-state hazards/forwarding plus hold, timeout and reset sequences.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        mr_e, redir, wm, mr_m, req, ack, ww;
    logic        s_if, s_id, s_ex, s_mem, f_id, f_ex, tmo;
    logic [1:0]  fa, fb;
    logic [31:0] sc_o, fc_o;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WAIT_MAX(8), .CNT_W(32)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
        .i_rd_e(rd_e), .i_mem_read_e(mr_e), .i_redirect_e(redir),
        .i_rd_m(rd_m), .i_rd_wren_m(wm), .i_mem_read_m(mr_m),
        .i_dmem_req_m(req), .i_dmem_ack(ack), .i_rd_w(rd_w), .i_rd_wren_w(ww),
        .o_stall_if(s_if), .o_stall_id(s_id), .o_stall_ex(s_ex), .o_stall_mem(s_mem),
        .o_flush_id(f_id), .o_flush_ex(f_ex), .o_fwd_a(fa), .o_fwd_b(fb),
        .o_mem_timeout(tmo), .o_stall_cnt(sc_o), .o_flush_cnt(fc_o)
    );

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        int rs1_d, rs2_d, rs1_e, rs2_e, rd_e, mr_e, redir, rd_m, wm, mr_m, rd_w, ww, ctl, fa, fb;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int sc = 0;
    int fc = 0;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ctl();
        return 32'({s_if, s_id, s_ex, s_mem, f_id, f_ex});
    endfunction

    task automatic clr();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {mr_e, redir, wm, mr_m, req, ack, ww} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_stall_cnt"}, sc_o, PERF ? 32'(sc) : 32'd0);
        chk({nm, "_flush_cnt"}, fc_o, PERF ? 32'(fc) : 32'd0);
    endtask

    initial begin
        //          rs1d rs2d rs1e rs2e rde mre rdr rdm wm mrm rdw ww  ctl        fa fb
        tbl[0]  = '{0,   0,   0,   0,   0,  0,  0,  0,  0, 0,  0,  0,  'b000000,  0, 0};
        tbl[1]  = '{5,   0,   0,   0,   5,  1,  0,  0,  0, 0,  0,  0,  'b110001,  0, 0};
        tbl[2]  = '{0,   0,   0,   0,   0,  0,  0,  0,  0, 0,  0,  0,  'b000000,  0, 0};
        tbl[3]  = '{0,   7,   0,   0,   7,  1,  0,  0,  0, 0,  0,  0,  'b110001,  0, 0};
        tbl[4]  = '{0,   0,   0,   0,   0,  1,  0,  0,  0, 0,  0,  0,  'b000000,  0, 0};
        tbl[5]  = '{5,   0,   0,   0,   5,  0,  0,  0,  0, 0,  0,  0,  'b000000,  0, 0};
        tbl[6]  = '{5,   0,   0,   0,   5,  1,  1,  0,  0, 0,  0,  0,  'b000011,  0, 0};
        tbl[7]  = '{0,   0,   0,   0,   0,  0,  1,  0,  0, 0,  0,  0,  'b000011,  0, 0};
        tbl[8]  = '{0,   0,   3,   0,   0,  0,  0,  3,  1, 0,  3,  1,  'b000000,  2, 0};
        tbl[9]  = '{0,   0,   3,   0,   0,  0,  0,  3,  1, 1,  3,  1,  'b000000,  1, 0};
        tbl[10] = '{0,   0,   3,   0,   0,  0,  0,  0,  1, 0,  0,  1,  'b000000,  0, 0};
        tbl[11] = '{0,   0,   9,   4,   0,  0,  0,  4,  0, 0,  4,  1,  'b000000,  0, 1};
        tbl[12] = '{0,   0,   6,   8,   0,  0,  0,  6,  1, 0,  8,  1,  'b000000,  2, 1};
        tbl[13] = '{0,   0,   3,   0,   0,  0,  0,  0,  0, 0,  3,  0,  'b000000,  0, 0};
        tbl[14] = '{0,   2,   2,   2,   2,  1,  0,  2,  1, 0,  2,  1,  'b110001,  2, 2};

        // Reset held while inputs would otherwise stall, flush and forward.
        rst_n = 1'b0;
        clr();
        rs1_d = 5; rd_e = 5; mr_e = 1; redir = 1; req = 1;
        rs1_e = 3; rd_m = 3; wm = 1;
        #12;
        chk("rst_ctl", ctl(), 0);
        chk("rst_fwd_a", 32'(fa), 0);
        chk("rst_timeout", 32'(tmo), 0);
        chk_cnt("rst");
        clr();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            rs1_d = 5'(tbl[i].rs1_d); rs2_d = 5'(tbl[i].rs2_d);
            rs1_e = 5'(tbl[i].rs1_e); rs2_e = 5'(tbl[i].rs2_e);
            rd_e = 5'(tbl[i].rd_e);   mr_e = 1'(tbl[i].mr_e); redir = 1'(tbl[i].redir);
            rd_m = 5'(tbl[i].rd_m);   wm = 1'(tbl[i].wm);     mr_m = 1'(tbl[i].mr_m);
            rd_w = 5'(tbl[i].rd_w);   ww = 1'(tbl[i].ww);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), ctl(), 32'(tbl[i].ctl));
            chk($sformatf("vec%0d_fwd_a", i), 32'(fa), 32'(tbl[i].fa));
            chk($sformatf("vec%0d_fwd_b", i), 32'(fb), 32'(tbl[i].fb));
            if (tbl[i].ctl[5]) sc++;
            if (tbl[i].ctl[1]) fc++;
            tick();
        end
        chk_cnt("table");

        // Memory hold with a redirect waiting in EX: frozen 4 cycles, redirect taken on ack.
        clr();
        req = 1; redir = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_ctl", k), ctl(), 'b111100);
            sc++;
            tick();
        end
        ack = 1;
        @(negedge clk);
        chk("ack_ctl", ctl(), 'b000011);
        fc++;
        tick();
        clr();
        @(negedge clk);
        chk("after_ack_ctl", ctl(), 0);
        tick();
        chk_cnt("hold");

        // Timeout: one RUN hold cycle plus MEM_WAIT up to the wait limit, then ERR.
        clr();
        req = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("wait%0d_ctl", k), ctl(), 'b111100);
            chk($sformatf("wait%0d_timeout", k), 32'(tmo), 0);
            sc++;
            tick();
        end
        @(negedge clk);
        chk("err_timeout", 32'(tmo), 1);
        chk("err_ctl", ctl(), 'b111100);
        sc++;
        tick();
        ack = 1; redir = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("err_ack%0d_ctl", k), ctl(), 'b111100);
            chk($sformatf("err_ack%0d_timeout", k), 32'(tmo), 1);
            sc++;
            tick();
        end
        chk_cnt("err");

        // Reset clears the sticky error.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("err_rst_ctl", ctl(), 0);
        chk("err_rst_timeout", 32'(tmo), 0);
        sc = 0; fc = 0;
        chk_cnt("err_rst");
        clr();
        #1 rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_err_ctl", ctl(), 0);
        chk("post_err_timeout", 32'(tmo), 0);
        tick();

        // Asynchronous reset between edges while in MEM_WAIT.
        clr();
        req = 1;
        tick();
        tick();
        rs1_e = 3; rd_m = 3; wm = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("mw_rst_ctl", ctl(), 0);
        chk("mw_rst_fwd_a", 32'(fa), 0);
        #1 rst_n = 1'b1;
        clr();
        tick();
        @(negedge clk);
        chk("mw_post_ctl", ctl(), 0);
        chk_cnt("mw_post");
        rs1_d = 5; rd_e = 5; mr_e = 1;
        @(negedge clk);
        chk("mw_lu_ctl", ctl(), 'b110001);
        sc++;
        tick();
        clr();
        @(negedge clk);
        chk("mw_lu_done_ctl", ctl(), 0);
        chk_cnt("mw_lu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
